// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared types and constants for the PLL lock supervisor:
//               supervisor state enum, retry counter width and a helper
//               used to size the shared phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

  localparam int c_RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Largest of the three phase lengths; the shared counter must reach it.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_sup_sync.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_sync
// Description : Two-flop synchroniser bringing the asynchronous rPLL LOCK
//               signal into the clkin domain.
// Ports       : clkin  - reference clock
//               reset  - asynchronous active-high reset, clears both flops
//               d      - asynchronous input
//               q      - synchronised output (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module pll_sup_sync (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Sequences rPLL reset, waits for a synchronised lock, demands
//               a stable lock window before releasing the PLL-domain reset,
//               retries on timeout and latches a fault after MAX_RETRIES
//               failed attempts.
// Ports       : clkin           - 27 MHz reference clock (only clock)
//               reset           - asynchronous active-high reset
//               pll_lock        - rPLL LOCK, asynchronous
//               relock_req      - single-cycle restart request
//               pll_reset       - drives rPLL RESET
//               sys_reset       - active-high reset for PLL-clocked logic
//               ready           - PLL locked and stable
//               fault           - retry limit exhausted
//               retry_count     - failed attempts in current sequence
//               lock_loss_count - (PLL_SUP_LOSS_COUNT_EN only) saturating
//                                 count of lock losses while running
// Options     : define PLL_SUP_LOSS_COUNT_EN to add lock_loss_count.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 pll_lock,
  input  logic                 relock_req,
  output logic                 pll_reset,
  output logic                 sys_reset,
  output logic                 ready,
  output logic                 fault,
  output logic [c_RETRY_W-1:0] retry_count
`ifdef PLL_SUP_LOSS_COUNT_EN
  ,
  output logic [7:0]           lock_loss_count
`endif
);

  localparam int CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: each phase lasts exactly N cycles, counter runs 0..N-1
  // and is cleared on the transition, so it can never wrap.
  localparam logic [CNT_W-1:0]     c_RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]     c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY   = c_RETRY_W'(MAX_RETRIES);

  logic lock_s;

  pll_sup_sync u_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_t               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [c_RETRY_W-1:0] retry_d, retry_q;
  logic                 pll_reset_d, pll_reset_q;
  logic                 sys_reset_d, sys_reset_q;
  logic                 ready_d, ready_q;
  logic                 fault_d, fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (relock_req) begin
      // Restart request overrides lock loss and every timer.
      state_d = ST_RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == c_RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == c_LOCK_LAST) begin
            cnt_d   = '0;
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == c_MAX_RETRY) ? ST_FAULT : ST_RST_PLL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STABLE: begin
          // A single dropout restarts the window but is not a failed attempt.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == c_STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RST_PLL;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RST_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] loss_d, loss_q;

  // Counts RUN-to-RST_PLL lock losses only; survives relock_req.
  always_comb begin
    loss_d = loss_q;
    if (!relock_req && (state_q == ST_RUN) && !lock_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_count = loss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor. A stimulus
//               process drives directed and random lock waveforms, steps a
//               phase-level reference model and queues the expected outputs
//               per cycle; a monitor pops and compares them on the falling
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 3;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_reset, sys_reset, ready, fault;
  logic [2:0] retry_count;
`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  always #5 clkin = ~clkin;

  pll_lock_supervisor #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clkin       (clkin),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_reset   (pll_reset),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
`ifdef PLL_SUP_LOSS_COUNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum {P_RESETTING, P_WAITING, P_SETTLING, P_RUNNING, P_FAULTED} phase_t;

  typedef struct {
    int         cyc;
    logic       pr;
    logic       sr;
    logic       rdy;
    logic       flt;
    logic [2:0] rc;
    logic [7:0] llc;
  } exp_t;

  exp_t   sb[$];
  phase_t m_phase;
  int     m_elapsed, m_retries, m_losses;
  bit     m_s1, m_s2;
  bit     m_prev_reset, m_prev_lock, m_prev_relock;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clkin) cyc++;

  task automatic m_clear();
    m_phase   = P_RESETTING;
    m_elapsed = 0;
    m_retries = 0;
    m_losses  = 0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
  endtask

  task automatic m_enter(input phase_t p);
    m_phase   = p;
    m_elapsed = 0;
  endtask

  // One rising clock edge, using the inputs held during the previous cycle.
  task automatic m_edge();
    bit ls;
    if (m_prev_reset) begin
      m_clear();
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = m_prev_lock;
    if (m_prev_relock) begin
      m_retries = 0;
      m_enter(P_RESETTING);
      return;
    end
    case (m_phase)
      P_RESETTING: begin
        m_elapsed++;
        if (m_elapsed == RC) m_enter(P_WAITING);
      end
      P_WAITING: begin
        if (ls) m_enter(P_SETTLING);
        else begin
          m_elapsed++;
          if (m_elapsed == LT) begin
            m_retries++;
            m_enter((m_retries == MR) ? P_FAULTED : P_RESETTING);
          end
        end
      end
      P_SETTLING: begin
        if (!ls) m_enter(P_WAITING);
        else begin
          m_elapsed++;
          if (m_elapsed == SC) begin
            m_retries = 0;
            m_enter(P_RUNNING);
          end
        end
      end
      P_RUNNING: begin
        if (!ls) begin
          if (m_losses < 255) m_losses++;
          m_enter(P_RESETTING);
        end
      end
      default: ;
    endcase
  endtask

  // Advance one cycle: clock edge, then new inputs (reset acts at once).
  task automatic drive_cycle(input bit rst, input bit lk, input bit rl);
    exp_t e;
    @(posedge clkin);
    #1;
    m_edge();
    reset      = rst;
    pll_lock   = lk;
    relock_req = rl;
    if (rst) m_clear();
    m_prev_reset  = rst;
    m_prev_lock   = lk;
    m_prev_relock = rl;
    e.cyc = cyc;
    e.pr  = (m_phase == P_RESETTING) || (m_phase == P_FAULTED);
    e.sr  = (m_phase != P_RUNNING);
    e.rdy = (m_phase == P_RUNNING);
    e.flt = (m_phase == P_FAULTED);
    e.rc  = 3'(m_retries);
    e.llc = 8'(m_losses);
    sb.push_back(e);
  endtask

  task automatic hold(input int n, input bit lk);
    repeat (n) drive_cycle(1'b0, lk, 1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clkin);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("pll_reset",   e.cyc, int'(pll_reset),   int'(e.pr));
        check("sys_reset",   e.cyc, int'(sys_reset),   int'(e.sr));
        check("ready",       e.cyc, int'(ready),       int'(e.rdy));
        check("fault",       e.cyc, int'(fault),       int'(e.flt));
        check("retry_count", e.cyc, int'(retry_count), int'(e.rc));
`ifdef PLL_SUP_LOSS_COUNT_EN
        check("lock_loss_count", e.cyc, int'(lock_loss_count), int'(e.llc));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int len;
    bit lk;
    m_clear();
    m_prev_reset  = 1'b1;
    m_prev_lock   = 1'b0;
    m_prev_relock = 1'b0;

    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    // Clean lock: rise 10 cycles after pll_reset falls.
    hold(RC + 10, 1'b0);
    hold(25, 1'b1);
    // Lock loss in RUN, then reacquire.
    hold(2, 1'b0);
    hold(30, 1'b1);
    // Lock loss, then unstable reacquire (5 high, 1 low, steady).
    hold(7, 1'b0);
    hold(5, 1'b1);
    hold(1, 1'b0);
    hold(25, 1'b1);
    // Never lock: exhaust retries into FAULT.
    hold(3 * (RC + LT) + 20, 1'b0);
    // Recovery from FAULT with relock_req.
    drive_cycle(1'b0, 1'b0, 1'b1);
    hold(10, 1'b0);
    hold(25, 1'b1);
    // Lose lock, reacquire and reset asynchronously mid-STABLE.
    hold(9, 1'b0);
    hold(6, 1'b1);
    repeat (2) drive_cycle(1'b1, 1'b1, 1'b0);
    hold(30, 1'b1);

    // Randomised lock waveforms with occasional relock and reset.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
      end else if (r < 8) begin
        drive_cycle(1'b0, pll_lock, 1'b1);
      end else begin
        lk  = (r < 30) ? 1'b0 : 1'b1;
        len = (r < 15) ? int'($urandom_range(60, 160)) : int'($urandom_range(1, 30));
        hold(len, lk);
      end
    end

    hold(3, 1'b1);
    @(negedge clkin);
    @(negedge clkin);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of clkin cycles pll_reset is held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum number of cycles to wait for lock per attempt.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: number of consecutive cycles lock must hold before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: number of failed attempts before FAULT, range 1..7.
REQ-005 SHALL have port clkin, input, 1 bit: free-running 27 MHz reference clock and the only clock of the block.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1 bit: rPLL LOCK output, asynchronous to clkin.
REQ-008 SHALL have port relock_req, input, 1 bit: single-cycle request to restart the sequence.
REQ-009 SHALL have port pll_reset, output, 1 bit: drives rPLL RESET.
REQ-010 SHALL have port sys_reset, output, 1 bit: active-high reset for logic clocked by the PLL output.
REQ-011 SHALL have port ready, output, 1 bit: high when the PLL is locked and stable.
REQ-012 SHALL have port fault, output, 1 bit: high when the retry limit is exhausted.
REQ-013 SHALL have port retry_count, output, 3 bits: number of failed attempts in the current sequence.

Function
REQ-014 SHALL synchronise pll_lock through two flops into lock_s; all decisions use lock_s (2-cycle latency).
REQ-015 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT with a single shared cycle counter cleared on every state entry.
REQ-016 RST_PLL: pll_reset=1 for exactly RESET_CYCLES cycles, then transition to WAIT_LOCK.
REQ-017 WAIT_LOCK: if lock_s=1, go to STABLE; if the counter reaches LOCK_TIMEOUT with lock_s=0, increment retry_count.
REQ-018 WAIT_LOCK timeout: if the incremented retry_count equals MAX_RETRIES, go to FAULT; otherwise go to RST_PLL.
REQ-019 STABLE: lock_s=0 in any cycle returns to WAIT_LOCK without incrementing retry_count; after STABLE_CYCLES consecutive lock_s=1 cycles, go to RUN.
REQ-020 On entering RUN, retry_count SHALL clear to 0.
REQ-021 RUN: lock_s=0 SHALL cause a transition to RST_PLL.
REQ-022 FAULT: the block SHALL stay in FAULT until relock_req or reset.
REQ-023 relock_req in any state SHALL cause a transition to RST_PLL with retry_count cleared, and takes priority over lock loss and timers.
REQ-024 All outputs SHALL be registered, with values decoded from the next state.
REQ-025 pll_reset=1 in RST_PLL and FAULT.
REQ-026 sys_reset=0 only in RUN.
REQ-027 ready=1 only in RUN.
REQ-028 fault=1 only in FAULT.
REQ-029 On loss of lock in RUN, sys_reset SHALL rise and ready fall 3 cycles after the pll_lock falling edge (2 synchroniser cycles plus 1 register cycle).
REQ-030 pll_lock glitches shorter than one cycle may be missed; this is acceptable behaviour.
REQ-031 The counter SHALL be sized to max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and SHALL never wrap.

Reset
REQ-032 While reset=1: state=RST_PLL, counter=0, synchroniser flops=0, retry_count=0, pll_reset=1, sys_reset=1, ready=0, fault=0.
REQ-033 Reset deassertion SHALL start a full RST_PLL phase; reset mid-sequence SHALL abort to these values immediately.

Configuration
REQ-034 Macro PLL_SUP_LOSS_COUNT_EN defined: add output lock_loss_count, 8 bits, incremented on each RUN-to-RST_PLL lock loss, saturating at 255, cleared only by reset.
REQ-035 PLL_SUP_LOSS_COUNT_EN undefined: no lock_loss_count port and no counter logic.

Structure
REQ-036 Package pll_sup_pkg SHALL hold the state enum type and the retry_count width constant (3).
REQ-037 The two-flop synchroniser SHALL be a sub-module named pll_sup_sync; all other logic SHALL be in pll_lock_supervisor.

Verification (bench parameters RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-038 Clean lock: release reset, raise pll_lock 10 cycles after pll_reset falls -> pll_reset high for 4 cycles; ready=1 and sys_reset=0 exactly 2+8+1 cycles after the pll_lock rise.
REQ-039 Never lock: hold pll_lock=0 -> three pll_reset pulses of 4 cycles each, retry_count steps 1,2; fault=1 after the third timeout; pll_reset stays 1.
REQ-040 Unstable lock: pll_lock high for 5 cycles, low for 1, then steady -> STABLE restarts, retry_count stays 0, ready is delayed by a full 8 stable cycles.
REQ-041 Lock loss in RUN: drop pll_lock -> sys_reset=1 and ready=0 after 3 cycles, followed by a 4-cycle pll_reset pulse; lock_loss_count=1 when the macro is defined.
REQ-042 Recovery: relock_req pulse in FAULT -> fault=0 next cycle, retry_count=0, new RST_PLL phase; assert async reset mid-STABLE -> all outputs take reset values without waiting for a clock edge.
